// File: rtl/demux_stream_router.sv
// Registered 1-to-4 valid/ready stream router: holds one beat and steers it to an addressed or round-robin channel.
// Optional per-channel saturating beat counters are enabled by defining DEMUX_BEAT_COUNT_EN.
module demux_stream_router #(
  parameter int DW = 8
`ifdef DEMUX_BEAT_COUNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic          in_valid,
  input  logic [1:0]    in_sel,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [3:0]    out_valid,
  output logic [DW-1:0] out_data,
  input  logic [3:0]    out_ready,
  output logic [1:0]    rr_ptr
`ifdef DEMUX_BEAT_COUNT_EN
  , output logic [4*CNT_W-1:0] beat_cnt
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state;
  logic       in_fire;
  logic       out_fire;
  logic [1:0] ch;

  // out_valid is one-hot, so only the held channel's ready bit can complete a transfer.
  assign out_fire = |(out_valid & out_ready);
  assign in_ready = (state == EMPTY) || out_fire;
  assign in_fire  = in_valid && in_ready;
  assign ch       = mode ? rr_ptr : in_sel;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 4'b0000;
      out_data  <= '0;
      rr_ptr    <= 2'b00;
    end else if (in_fire) begin
      // Loading over a draining beat is the same path, so there is no bubble.
      state     <= FULL;
      out_valid <= 4'b0001 << ch;
      out_data  <= in_data;
      if (mode) rr_ptr <= rr_ptr + 2'd1;
    end else if (out_fire) begin
      state     <= EMPTY;
      out_valid <= 4'b0000;
    end
  end

`ifdef DEMUX_BEAT_COUNT_EN
  for (genvar n = 0; n < 4; n++) begin : g_cnt
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (out_valid[n] && out_ready[n] && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign beat_cnt[n*CNT_W +: CNT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_demux_stream_router.sv
// Scoreboard bench for demux_stream_router: stimulus pushes hand-computed expected beats, a monitor pops them on output handshakes.
// Define DEMUX_BEAT_COUNT_EN to also exercise the saturating beat counters.
module tb_demux_stream_router;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic       in_valid;
  logic [1:0] in_sel;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] out_valid;
  logic [7:0] out_data;
  logic [3:0] out_ready;
  logic [1:0] rr_ptr;
`ifdef DEMUX_BEAT_COUNT_EN
  logic [31:0] beat_cnt;
`endif

  typedef struct packed {
    logic [3:0] v;
    logic [7:0] d;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] model_rr = 2'd0;
  int         waited;

  demux_stream_router #(.DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr)
`ifdef DEMUX_BEAT_COUNT_EN
    , .beat_cnt (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      check("onehot0", 64'($onehot0(out_valid)), 64'd1);
      if (|(out_valid & out_ready)) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_out: got out_valid=%b data=0x%0h, expected no delivery", out_valid, out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_out_valid", 64'(out_valid), 64'(e.v));
          check("sb_out_data", 64'(out_data), 64'(e.d));
        end
      end
    end
  end

  // Present one beat; wait (bounded) for acceptance, then push its expected channel/payload.
  task automatic send(input logic m, input logic [1:0] s, input logic [7:0] d,
                      input logic [3:0] exp_v, output int w);
    mode = m; in_sel = s; in_data = d; in_valid = 1'b1; w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 after %0d cycles, expected 1", w);
      in_valid = 1'b0;
      return;
    end
    check("rr_ptr_at_fire", 64'(rr_ptr), 64'(model_rr));
    sb.push_back('{v: exp_v, d: d});
    if (m) model_rr = model_rr + 2'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'hF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_rr_ptr", 64'(rr_ptr), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Addressed mode: 0xA5 to channel 2, then empty again
    send(1'b0, 2'd2, 8'hA5, 4'b0100, waited);
    @(negedge clk);
    check("addr_out_valid", 64'(out_valid), 64'b0100);
    @(negedge clk);
    check("addr_empty_valid", 64'(out_valid), 64'd0);
    check("addr_empty_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Round-robin back-to-back with wrap
    send(1'b1, 2'd3, 8'h10, 4'b0001, waited); check("rr_no_stall0", 64'(waited), 64'd0);
    send(1'b1, 2'd3, 8'h11, 4'b0010, waited); check("rr_no_stall1", 64'(waited), 64'd0);
    send(1'b1, 2'd0, 8'h12, 4'b0100, waited); check("rr_no_stall2", 64'(waited), 64'd0);
    send(1'b1, 2'd0, 8'h13, 4'b1000, waited); check("rr_no_stall3", 64'(waited), 64'd0);
    send(1'b1, 2'd2, 8'h14, 4'b0001, waited); check("rr_no_stall4", 64'(waited), 64'd0);
    @(negedge clk);
    check("rr_ptr_wrapped", 64'(rr_ptr), 64'd1);
    @(posedge clk); #1;

    // Backpressure on channel 1 for 5 cycles
    out_ready = 4'b1101;
    send(1'b0, 2'd1, 8'h3C, 4'b0010, waited);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'b0010);
      check("bp_out_data", 64'(out_data), 64'h3C);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 4'hF;
    @(negedge clk);
    @(negedge clk);
    check("bp_drained", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Simultaneous drain/fill: held ch0 beat leaves as 0x77 for ch3 enters
    out_ready = 4'b1110;
    send(1'b0, 2'd0, 8'h55, 4'b0001, waited);
    @(negedge clk);
    check("df_stalled_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    out_ready = 4'hF;
    send(1'b0, 2'd3, 8'h77, 4'b1000, waited);
    check("df_accept_same_cycle", 64'(waited), 64'd0);
    @(negedge clk);
    check("df_out_valid", 64'(out_valid), 64'b1000);
    check("df_out_data", 64'(out_data), 64'h77);
    @(posedge clk); #1;

    // Reset mid-operation with a stalled beat on ch2 (rr_ptr is 1 here)
    out_ready = 4'b1011;
    send(1'b0, 2'd2, 8'h99, 4'b0100, waited);
    @(negedge clk);
    check("mid_held", 64'(out_valid), 64'b0100);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hEE;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 4'hF;
    sb.delete();
    model_rr = 2'd0;
    @(negedge clk);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_rr", 64'(rr_ptr), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);

    // Reset while EMPTY with an offered beat: nothing may be emitted
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h42;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_fire_dropped", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

`ifdef DEMUX_BEAT_COUNT_EN
    for (int i = 0; i < 300; i++) send(1'b0, 2'd1, 8'(i), 4'b0010, waited);
    repeat (2) @(negedge clk);
    check("cnt_saturated", 64'(beat_cnt), 64'h0000_FF00);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("cnt_cleared", 64'(beat_cnt), 64'd0);
    @(posedge clk); #1;
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
